// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART types and parity helper for the framed tx/rx blocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   localparam int MAX_BPW = 9;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'd0,
      PAR_EVEN  = 2'd1,
      PAR_ODD   = 2'd2,
      PAR_NONE3 = 2'd3
   } parity_e;

   // Narrower words are zero-extended by the caller; zeros do not change the XOR.
   function automatic logic calc_parity(input logic [MAX_BPW-1:0] data, input parity_e mode);
      case (mode)
         PAR_EVEN: return ^data;
         PAR_ODD:  return ~^data;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick : bit-period down-counter, one-cycle tick at the end of each period
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart_i,
   input  logic [DIV_W-1:0] period_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q;

   // period_i is never zero here; the top clamps it before use.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (restart_i || (cnt_q == '0)) begin
         cnt_q <= period_i - DIV_W'(1);
      end else begin
         cnt_q <= cnt_q - DIV_W'(1);
      end
   end

   assign tick_o = (cnt_q == '0) && !restart_i;

endmodule

`default_nettype wire

// File: rtl/uart_tx_framed.sv
// ---------------------------------------------------------------------------
// uart_tx_framed : multi-word UART transmitter with one-beat holding buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_framed
   import uart_pkg::*;
#(
   parameter int BITS_PER_WORD = 8,
   parameter int NUM_WORDS     = 3,
   parameter int DIV_W         = 16,
   parameter int DEF_CLKS      = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [DIV_W-1:0]                   cfg_clks_per_bit,
   input  logic [1:0]                         cfg_parity,
   input  logic                               cfg_two_stop,
   input  logic                               s_valid,
   output logic                               s_ready,
   input  logic [NUM_WORDS*BITS_PER_WORD-1:0] s_data,
   output logic                               tx,
   output logic                               busy,
   output logic                               done
);

   localparam int BEAT_W = NUM_WORDS * BITS_PER_WORD;
   localparam int WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int BIT_W  = $clog2(BITS_PER_WORD + 1);
   localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(NUM_WORDS - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(BITS_PER_WORD);
   localparam logic [DIV_W-1:0]  DEF_PERIOD = (DEF_CLKS < 1) ? DIV_W'(1) : DIV_W'(DEF_CLKS);

   logic                     hold_full_q, hold_full_d;
   logic [BEAT_W-1:0]        hold_data_q;
   logic [BEAT_W-1:0]        beat_q;
   logic [BITS_PER_WORD-1:0] shift_q;
   tx_state_e                state_q;
   logic [WORD_W-1:0]        word_q;
   logic [BIT_W-1:0]         bit_q;
   logic [DIV_W-1:0]         clks_q;
   parity_e                  par_mode_q;
   logic                     two_stop_q;
   logic                     par_bit_q;
   logic                     stop_left_q;
   logic                     tx_q, busy_q, done_q;

   logic             w_accept, w_load, w_tick;
   logic [DIV_W-1:0] w_cfg_clks, w_period;

   assign w_accept    = s_valid && !hold_full_q;
   assign w_load      = (state_q == IDLE) && hold_full_q;
   assign hold_full_d = w_accept || (hold_full_q && !w_load);
   assign w_cfg_clks  = (cfg_clks_per_bit == '0) ? DIV_W'(1) : cfg_clks_per_bit;
   assign w_period    = w_load ? w_cfg_clks : clks_q;

   assign s_ready = !hold_full_q;
   assign tx      = tx_q;
   assign busy    = busy_q;
   assign done    = done_q;

   uart_baud_tick #(
      .DIV_W (DIV_W)
   ) u_baud (
      .clk       (clk),
      .rst       (rst),
      .restart_i (w_load),
      .period_i  (w_period),
      .tick_o    (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
      end else begin
         hold_full_q <= hold_full_d;
         if (w_accept) begin
            hold_data_q <= s_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         shift_q     <= '0;
         word_q      <= '0;
         bit_q       <= '0;
         clks_q      <= DEF_PERIOD;
         par_mode_q  <= PAR_NONE;
         two_stop_q  <= 1'b0;
         par_bit_q   <= 1'b0;
         stop_left_q <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (w_load) begin
                  beat_q     <= hold_data_q;
                  clks_q     <= w_cfg_clks;
                  par_mode_q <= parity_e'(cfg_parity);
                  two_stop_q <= cfg_two_stop;
                  word_q     <= '0;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= START;
               end
            end
            START: begin
               // Current word sits in the low bits of beat_q; pop it into the shifter.
               if (w_tick) begin
                  tx_q      <= beat_q[0];
                  shift_q   <= beat_q[BITS_PER_WORD-1:0] >> 1;
                  par_bit_q <= calc_parity(MAX_BPW'(beat_q[BITS_PER_WORD-1:0]), par_mode_q);
                  beat_q    <= beat_q >> BITS_PER_WORD;
                  bit_q     <= BIT_W'(1);
                  state_q   <= DATA;
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (bit_q == LAST_BIT) begin
                     if ((par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD)) begin
                        tx_q    <= par_bit_q;
                        state_q <= PARITY;
                     end else begin
                        tx_q        <= 1'b1;
                        stop_left_q <= two_stop_q;
                        state_q     <= STOP;
                     end
                  end else begin
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     bit_q   <= bit_q + BIT_W'(1);
                  end
               end
            end
            PARITY: begin
               if (w_tick) begin
                  tx_q        <= 1'b1;
                  stop_left_q <= two_stop_q;
                  state_q     <= STOP;
               end
            end
            STOP: begin
               if (w_tick) begin
                  if (stop_left_q) begin
                     stop_left_q <= 1'b0;
                  end else if (word_q == LAST_WORD) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     word_q  <= word_q + WORD_W'(1);
                     tx_q    <= 1'b0;
                     state_q <= START;
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_framed.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_framed : directed self-checking bench for uart_tx_framed
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_framed;

   localparam int BPW = 8;
   localparam int NW  = 3;
   localparam int DW  = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [DW-1:0]   cfg_clks_per_bit;
   logic [1:0]      cfg_parity;
   logic            cfg_two_stop;
   logic            s_valid;
   logic            s_ready;
   logic [NW*BPW-1:0] s_data;
   logic            tx;
   logic            busy;
   logic            done;

   int n_checks  = 0;
   int n_errors  = 0;
   int done_cnt  = 0;
   int done_snap = 0;
   bit rdy_bad;

   uart_tx_framed #(
      .BITS_PER_WORD (BPW),
      .NUM_WORDS     (NW),
      .DIV_W         (DW),
      .DEF_CLKS      (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_clks_per_bit (cfg_clks_per_bit),
      .cfg_parity       (cfg_parity),
      .cfg_two_stop     (cfg_two_stop),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .s_data           (s_data),
      .tx               (tx),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Samples one full frame, one negedge per clock, starting with the first start-bit cycle.
   task automatic check_word(input string tag, input logic [7:0] w, input int n,
                             input bit has_par, input bit par_bit, input bit two);
      int   nbits;
      logic exp;
      nbits = 1 + BPW + (has_par ? 1 : 0) + (two ? 2 : 1);
      for (int b = 0; b < nbits; b++) begin
         if (b == 0)                          exp = 1'b0;
         else if (b <= BPW)                   exp = w[b-1];
         else if (has_par && (b == BPW + 1))  exp = par_bit;
         else                                 exp = 1'b1;
         for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check($sformatf("%s.b%0d", tag, b), tx, exp);
            if (b == 0 && c == 0) check($sformatf("%s.busy", tag), busy, 1);
         end
      end
   endtask

   task automatic check_beat(input string tag, input logic [23:0] d, input int n,
                             input bit has_par, input logic [2:0] pbits, input bit two);
      for (int i = 0; i < NW; i++) begin
         check_word($sformatf("%s.w%0d", tag, i), d[i*BPW +: BPW], n, has_par, pbits[i], two);
      end
      @(negedge clk);
      check({tag, ".done"}, done, 1);
      check({tag, ".idle_tx"}, tx, 1);
      check({tag, ".idle_busy"}, busy, 0);
   endtask

   task automatic send_single(input logic [23:0] d);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      @(negedge clk);
      check("lat.tx", tx, 1);
      check("lat.rdy", s_ready, 0);
      s_valid = 1'b0;
      s_data  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst              = 1'b1;
      s_valid          = 1'b0;
      s_data           = '0;
      cfg_clks_per_bit = 16'd4;
      cfg_parity       = 2'd0;
      cfg_two_stop     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.tx", tx, 1);
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check("rst.rdy", s_ready, 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle.tx", tx, 1);
      check("idle.rdy", s_ready, 1);

      // 1: three words, no parity, 4 clk/bit; done lands 120 clocks after the start bit
      send_single(24'hC35A01);
      check_beat("t1", 24'hC35A01, 4, 0, 3'b000, 0);

      // 2: words 07, FF, 80 -> even parity 1,0,1 and odd parity 0,1,0
      cfg_clks_per_bit = 16'd2;
      cfg_parity       = 2'd1;
      send_single(24'h80FF07);
      check_beat("t2e", 24'h80FF07, 2, 1, 3'b101, 0);
      cfg_parity = 2'd2;
      send_single(24'h80FF07);
      check_beat("t2o", 24'h80FF07, 2, 1, 3'b010, 0);

      // 3: two stop bits at one clock per bit, then clks=0 which must behave as 1
      cfg_parity       = 2'd0;
      cfg_two_stop     = 1'b1;
      cfg_clks_per_bit = 16'd1;
      send_single(24'h030201);
      check_beat("t3c1", 24'h030201, 1, 0, 3'b000, 1);
      cfg_clks_per_bit = 16'd0;
      send_single(24'h030201);
      check_beat("t3c0", 24'h030201, 1, 0, 3'b000, 1);

      // 4: second beat held valid behind the first
      cfg_two_stop     = 1'b0;
      cfg_clks_per_bit = 16'd2;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 24'h332211;
      @(negedge clk);
      check("t4.rdy_full", s_ready, 0);
      s_data = 24'hCCBBAA;
      fork
         check_beat("t4a", 24'h332211, 2, 0, 3'b000, 0);
         begin
            @(negedge clk);
            check("t4.rdy_free", s_ready, 1);
            @(negedge clk);
            s_valid = 1'b0;
            check("t4.rdy_taken", s_ready, 0);
            rdy_bad = 1'b0;
            repeat (59) begin
               @(negedge clk);
               if (s_ready !== 1'b0) rdy_bad = 1'b1;
            end
            check("t4.rdy_held", rdy_bad, 0);
         end
      join
      check_beat("t4b", 24'hCCBBAA, 2, 0, 3'b000, 0);
      check("t4.rdy_end", s_ready, 1);

      // 5: bit period changed mid-beat only affects the queued beat
      cfg_clks_per_bit = 16'd4;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 24'h0F55A5;
      @(negedge clk);
      s_data = 24'h81427E;
      fork
         check_beat("t5a", 24'h0F55A5, 4, 0, 3'b000, 0);
         begin
            @(negedge clk);
            @(negedge clk);
            s_valid = 1'b0;
            repeat (5) @(negedge clk);
            cfg_clks_per_bit = 16'd8;
         end
      join
      check_beat("t5b", 24'h81427E, 8, 0, 3'b000, 0);

      // 6: reset during DATA with a beat buffered
      cfg_clks_per_bit = 16'd4;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 24'h123456;
      @(negedge clk);
      s_data = 24'h654321;
      @(negedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      check("t6.rdy_full", s_ready, 0);
      repeat (5) @(negedge clk);
      check("t6.mid_busy", busy, 1);
      done_snap = done_cnt;
      #2 rst = 1'b1;
      #1;
      check("t6.rst_tx", tx, 1);
      check("t6.rst_busy", busy, 0);
      check("t6.rst_rdy", s_ready, 1);
      check("t6.rst_done", done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rdy_bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) rdy_bad = 1'b1;
      end
      check("t6.discarded", rdy_bad, 0);
      check("t6.no_done", done_cnt, done_snap);
      send_single(24'hA5C30F);
      check_beat("t6c", 24'hA5C30F, 4, 0, 3'b000, 0);

      repeat (3) @(negedge clk);
      check("done_total", done_cnt, 10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
